// File: rtl/pingpong_pkg.sv
// Shared state encoding and LED end-index helpers for the ping-pong controller.
package pingpong_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_TO_B = 3'b001,
    ST_TO_A = 3'b010,
    ST_PT_B = 3'b011,
    ST_PT_A = 3'b100,
    ST_OVER = 3'b101
  } state_t;

  localparam int B_END = 0;

  function automatic int a_end(input int n_led);
    return n_led - 1;
  endfunction

endpackage

// File: rtl/pingpong_step_div.sv
// Ball-step timer: one-cycle step pulse every STEP_DIV cycles, or every
// STEP_DIV/2 cycles while the ball is in smash speed.
module pingpong_step_div #(
  parameter int STEP_DIV = 12500000
) (
  input  logic CLK,
  input  logic RST,
  input  logic clear,
  input  logic enable,
  input  logic fast,
  output logic step
);

  localparam int CW = $clog2(STEP_DIV);
  localparam logic [CW-1:0] LAST_NORM = CW'(STEP_DIV - 1);
  localparam logic [CW-1:0] LAST_FAST = CW'(STEP_DIV / 2 - 1);

  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_last;

  assign w_last = fast ? LAST_FAST : LAST_NORM;
  // >= so a speed change mid-count can never skip past the terminal value
  assign step   = enable && (r_cnt >= w_last);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt <= '0;
    end else if (clear || step) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= r_cnt + CW'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

endmodule

// File: rtl/pingpong_core.sv
// Ping-pong game controller: ball position and timing, hit-window judging,
// foul/miss detection, scoring and game-over handling for players A and B.
module pingpong_core
  import pingpong_pkg::*;
#(
  parameter int N_LED     = 6,
  parameter int HIT_WIN   = 2,
  parameter int STEP_DIV  = 12500000,
  parameter int WIN_SCORE = 9,
  parameter int SW        = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  input  logic             SERVE_A,
  input  logic             SERVE_B,
  input  logic             HIT_A,
  input  logic             HIT_B,
  input  logic             SMASH_A,
  input  logic             SMASH_B,
  output logic [N_LED-1:0] LED,
  output logic [SW-1:0]    SCOREA,
  output logic [SW-1:0]    SCOREB,
  output logic [2:0]       STATE,
  output logic             FAST,
  output logic             GAME_OVER,
  output logic             WINNER_A,
  output logic             WINNER_B
);

  localparam int               A_END    = a_end(N_LED);
  localparam logic [SW-1:0]    WIN      = SW'(WIN_SCORE);
  localparam logic [N_LED-1:0] LED_AT_A = N_LED'(1) << A_END;
  localparam logic [N_LED-1:0] LED_AT_B = N_LED'(1) << B_END;

  state_t           r_state, w_next_state;
  logic [N_LED-1:0] r_led, w_led_next;
  logic             r_fast, w_fast_next;
  logic [SW-1:0]    r_score_a, r_score_b, w_score_a_next, w_score_b_next;
  logic             w_step, w_div_clear, w_div_en;
  logic             w_a_key, w_b_key, w_in_a_win, w_in_b_win, w_game_won;

  assign w_a_key    = HIT_A | SMASH_A;
  assign w_b_key    = HIT_B | SMASH_B;
  assign w_in_b_win = |r_led[HIT_WIN:1];
  assign w_in_a_win = |r_led[A_END-1:A_END-HIT_WIN];
  assign w_game_won = (r_score_a == WIN) || (r_score_b == WIN);
  assign w_div_en   = (r_state == ST_TO_A) || (r_state == ST_TO_B);

  pingpong_step_div #(
    .STEP_DIV(STEP_DIV)
  ) u_step_div (
    .CLK   (CLK),
    .RST   (RST),
    .clear (w_div_clear),
    .enable(w_div_en),
    .fast  (r_fast),
    .step  (w_step)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state   <= ST_IDLE;
      r_led     <= '0;
      r_fast    <= 1'b0;
      r_score_a <= '0;
      r_score_b <= '0;
    end else begin
      r_state   <= w_next_state;
      r_led     <= w_led_next;
      r_fast    <= w_fast_next;
      r_score_a <= w_score_a_next;
      r_score_b <= w_score_b_next;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (CLR) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_game_won)   w_next_state = ST_OVER;
          else if (SERVE_A) w_next_state = ST_TO_B;
          else if (SERVE_B) w_next_state = ST_TO_A;
          else              w_next_state = ST_IDLE;
        end
        ST_TO_B: begin
          if (w_b_key)             w_next_state = w_in_b_win ? ST_TO_A : ST_PT_A;
          else if (r_led[B_END])   w_next_state = ST_PT_A;
          else                     w_next_state = ST_TO_B;
        end
        ST_TO_A: begin
          if (w_a_key)             w_next_state = w_in_a_win ? ST_TO_B : ST_PT_B;
          else if (r_led[A_END])   w_next_state = ST_PT_B;
          else                     w_next_state = ST_TO_A;
        end
        ST_PT_A, ST_PT_B: w_next_state = ST_IDLE;
        ST_OVER:          w_next_state = ST_OVER;
        default:          w_next_state = ST_IDLE;
      endcase
    end
  end

  // Keys coinciding with a step are judged on the current LED, so a key
  // branch never also shifts the ball.
  always_comb begin
    w_led_next     = r_led;
    w_fast_next    = r_fast;
    w_score_a_next = r_score_a;
    w_score_b_next = r_score_b;
    w_div_clear    = 1'b0;
    if (CLR) begin
      w_led_next     = '0;
      w_fast_next    = 1'b0;
      w_score_a_next = '0;
      w_score_b_next = '0;
      w_div_clear    = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_game_won && (SERVE_A || SERVE_B)) begin
            w_led_next  = SERVE_A ? LED_AT_A : LED_AT_B;
            w_fast_next = 1'b0;
            w_div_clear = 1'b1;
          end else begin
            w_led_next  = '0;
          end
        end
        ST_TO_B: begin
          if (w_b_key && w_in_b_win) begin
            w_fast_next = SMASH_B;
            w_div_clear = 1'b1;
          end else if (w_b_key || r_led[B_END]) begin
            w_led_next  = '0;
            w_fast_next = 1'b0;
          end else if (w_step) begin
            w_led_next  = {1'b0, r_led[N_LED-1:1]};
          end else begin
            w_led_next  = r_led;
          end
        end
        ST_TO_A: begin
          if (w_a_key && w_in_a_win) begin
            w_fast_next = SMASH_A;
            w_div_clear = 1'b1;
          end else if (w_a_key || r_led[A_END]) begin
            w_led_next  = '0;
            w_fast_next = 1'b0;
          end else if (w_step) begin
            w_led_next  = {r_led[N_LED-2:0], 1'b0};
          end else begin
            w_led_next  = r_led;
          end
        end
        ST_PT_A: begin
          w_led_next     = '0;
          w_fast_next    = 1'b0;
          w_score_a_next = (r_score_a == WIN) ? r_score_a : r_score_a + SW'(1);
        end
        ST_PT_B: begin
          w_led_next     = '0;
          w_fast_next    = 1'b0;
          w_score_b_next = (r_score_b == WIN) ? r_score_b : r_score_b + SW'(1);
        end
        ST_OVER: begin
          w_led_next = '0;
        end
        default: begin
          w_led_next  = '0;
          w_fast_next = 1'b0;
        end
      endcase
    end
    GAME_OVER = (r_state == ST_OVER);
    WINNER_A  = GAME_OVER && (r_score_a == WIN);
    WINNER_B  = GAME_OVER && (r_score_b == WIN);
  end

  assign LED    = r_led;
  assign SCOREA = r_score_a;
  assign SCOREB = r_score_b;
  assign STATE  = r_state;
  assign FAST   = r_fast;

endmodule

// File: doc/pingpong_core.md
Name: pingpong_core

Overview:
- Registered, parametrised ping-pong game controller.
- Owns ball position (one-hot LED bar), ball-step timing, normal/smash speed, hit-window judging, foul detection, score counters and game-over handling for players A and B.
- Replaces the standalone combinational next-state block plus external state and score registers.
- Sits between the debounced key-pulse logic and the LED/7-segment drivers.

Parameters:
N_LED, 6, LED bar length; legal range 4 and above.
HIT_WIN, 2, hit-window width in LEDs at each end; legal range 1..N_LED-2.
STEP_DIV, 12500000, CLK cycles per ball step at normal speed; must be even and at least 2.
WIN_SCORE, 9, score at which the game ends.
SW, 4, score width; 2**SW must exceed WIN_SCORE.

Ports:
CLK  in  1  system clock
RST  in  1  asynchronous active-high reset
CLR  in  1  synchronous new-game pulse
SERVE_A  in  1  A serve pulse (one CLK wide, debounced upstream)
SERVE_B  in  1  B serve pulse
HIT_A  in  1  A normal-return pulse
HIT_B  in  1  B normal-return pulse
SMASH_A  in  1  A fast-return pulse
SMASH_B  in  1  B fast-return pulse
LED  out  N_LED  one-hot ball position; bit N_LED-1 = A end, bit 0 = B end
SCOREA  out  SW  A score
SCOREB  out  SW  B score
STATE  out  3  current state code, for debug and display
FAST  out  1  ball is in smash speed
GAME_OVER  out  1  high in OVER
WINNER_A  out  1  high in OVER when SCOREA==WIN_SCORE
WINNER_B  out  1  high in OVER when SCOREB==WIN_SCORE

Behaviour:
- Reset (async, RST=1): STATE=IDLE, LED=0, SCOREA=SCOREB=0, FAST=0, divider=0. All flags low.
- All other updates occur on the rising edge of CLK.
- CLR, any state: next cycle enters IDLE with LED=0, scores 0, FAST=0, divider 0. CLR beats every other input.
- Step divider:
  - Counts only in TO_A and TO_B.
  - Period is STEP_DIV normal, STEP_DIV/2 when FAST=1.
  - STEP is a one-cycle pulse when the count reaches period-1; the count then wraps to 0.
  - Cleared on serve and on every accepted return.
- IDLE:
  - LED=0.
  - If SCOREA==WIN_SCORE or SCOREB==WIN_SCORE, go to OVER (checked before keys).
  - Else SERVE_A: go to TO_B, LED = bit N_LED-1.
  - Else SERVE_B: go to TO_A, LED = bit 0.
  - SERVE_A wins if both serves arrive together.
  - FAST=0 on serve.
- TO_B (ball moving toward B): LED shifts right one bit per STEP.
  - B window = LED bits HIT_WIN..1.
  - SMASH_B with ball in window: go to TO_A, FAST=1.
  - Else HIT_B with ball in window: go to TO_A, FAST=0.
  - HIT_B or SMASH_B with ball outside the window: foul, go to PT_A.
  - Ball shifted onto bit 0: miss, go to PT_A on the next cycle.
  - A keys are ignored.
  - A key and STEP in the same cycle: the key is judged on the current LED and the ball does not advance.
- TO_A: mirror of TO_B.
  - Window = bits N_LED-1-HIT_WIN..N_LED-2.
  - Miss = ball reaches bit N_LED-1; foul and miss go to PT_B.
  - B keys are ignored.
- Returns: the ball reverses in place; the first STEP after the return moves it one bit away from the hitter.
- PT_A / PT_B: one cycle.
  - LED=0, FAST=0.
  - Scorer's count +1, saturating at WIN_SCORE.
  - Then go to IDLE.
- OVER: LED=0. GAME_OVER=1 and the matching WINNER flag set. All keys except CLR are ignored.
- Serve keys are ignored outside IDLE.
- Codes: IDLE=000, TO_B=001, TO_A=010, PT_B=011, PT_A=100, OVER=101. 110 and 111 are illegal and return to IDLE.

Decomposition:
- Package pingpong_pkg holds the state encodings and LED end-index helpers (A_END=N_LED-1, B_END=0).
- Sub-module pingpong_step_div holds the divider: inputs CLK, RST, clear, enable, fast; output step.

Test Plan:
(All scenarios use N_LED=6, HIT_WIN=2, STEP_DIV=4.)
- Reset mid-rally (LED=001000): LED=0, SCOREA=SCOREB=0, STATE=000, FAST=0 immediately, without waiting for a clock edge.
- SERVE_A, no hits: LED=100000, then 010000/001000/000100/000010/000001 every 4 CLK; PT_A follows; SCOREA=1; back to IDLE.
- SERVE_A, HIT_B while LED=000100: STATE=010, FAST=0; LED=001000 four cycles after the hit.
- SERVE_A, SMASH_B while LED=000010: FAST=1; LED=000100 two cycles later, then 001000 two cycles after that.
- SERVE_A, HIT_B while LED=010000 (early swing): foul, SCOREA increments; SERVE_B mid-rally has no effect.
- Drive SCOREB to 9: next IDLE cycle enters OVER with GAME_OVER=1, WINNER_B=1; SERVE_A is ignored; CLR gives IDLE with both scores 0.
